tdm_demux16: RTL and testbench
==============================

// Module: tdm_demux16
// PURPOSE
//  Time-division 1-to-16 demultiplexer: the receive end of the 16-channel bit-mux datapath.
//  Accepts one serialized bit per valid beat, 16 beats per frame, channel 0 marked by frame_sync.
//  Reassembles each frame into a 16-bit parallel word; publishes it atomically at frame end.
//  Sits after the serial link, feeding per-channel consumers.
// PARAMETERS
//  N_CH   16  channels per frame (fixed at 16 this revision; other values unsupported)
//  SEL_W  4   channel index width, $clog2(N_CH)
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      beat qualifier; in_bit/frame_sync ignored when low
//  in_bit      in   1      serial data bit for the current channel
//  frame_sync  in   1      high with in_valid on the channel-0 beat only
//  out_bus     out  N_CH   last complete frame; bit k = channel k
//  out_valid   out  1      one-cycle pulse when out_bus updates
//  frame_err   out  1      one-cycle pulse on a framing violation
//  parity_err  out  1      one-cycle pulse on parity mismatch (tied 0 without TDM_DEMUX_PARITY_EN)
//  cur_ch      out  SEL_W  channel index expected on the next beat
// BEHAVIOUR
//  Reset: state=HUNT, cur_ch=0, shadow=0, out_bus=0, out_valid=0, frame_err=0, parity_err=0.
//  HUNT: beats without frame_sync discarded silently. Beat with sync -> shadow[0]=in_bit, cur_ch=1, -> RUN.
//  RUN, beat, no sync: shadow[cur_ch]=in_bit; cur_ch++.
//   Beat at cur_ch=N_CH-1: frame done; cur_ch wraps to 0; -> PUBLISH path (see CONFIGURATION).
//  RUN, beat with sync at cur_ch!=0: frame_err pulse; partial frame dropped;
//   beat taken as new channel 0 (shadow[0]=in_bit, cur_ch=1), stay RUN.
//  RUN, cur_ch=0, beat without sync: frame_err pulse; -> HUNT; beat discarded.
//  RUN, cur_ch=0, beat with sync: normal frame start.
//  in_valid low: all state holds; gaps of any length inside a frame allowed.
//  Publish: out_bus <= {in_bit, shadow[N_CH-2:0]} registered; out_valid high the cycle after the
//   completing beat; out_bus holds until next publish. Latency = 1 clk from last accepted beat.
//  Back-to-back frames (sync on the beat right after the last beat) lose no data.
//  Async reset mid-frame: partial frame lost, outputs return to reset values immediately.
//  Error/valid pulses are single-cycle, never sticky; out_valid and frame_err never both high.
// CONFIGURATION
//  TDM_DEMUX_PARITY_EN defined: frame is N_CH+1 beats; beat N_CH is even parity over the 16 data bits.
//   After channel 15 -> PARITY state (cur_ch stays N_CH-1); next beat without sync is checked:
//   match -> publish as above; mismatch -> parity_err pulse, out_bus unchanged, out_valid low.
//   Either way -> RUN at cur_ch=0. Sync on parity beat -> frame_err, frame dropped, beat = new ch0.
//  Undefined: 16-beat frames, no PARITY state, parity_err constant 0.
// STRUCTURE
//  tdm_pkg: N_CH, SEL_W, state enum {HUNT, RUN, PARITY}.
//  One sub-module: tdm_ch_counter (SEL_W counter, inc/clear/load-1, last-channel flag).
//  Top holds FSM, shadow register, output register, pulse generation.
// TESTING
//  1 Reset, then frame 0xA5C3 (LSB first, sync on ch0) -> out_bus=0xA5C3, out_valid 1 cycle, 1 clk after beat 16.
//  2 Two back-to-back frames 0xFFFF, 0x0001 -> two out_valid pulses, out_bus 0xFFFF then 0x0001.
//  3 Sync reasserted at ch7 -> frame_err pulse; following 16 beats 0x1234 -> out_bus=0x1234, prior value kept till then.
//  4 Beat at ch0 without sync -> frame_err, FSM in HUNT; 5 unsynced beats ignored, cur_ch=0; next synced frame recovers.
//  5 Random in_valid gaps (0-5 clks) within frame 0xBEEF -> out_bus=0xBEEF; rst_n low at ch9 -> all outputs 0.
//  6 PARITY_EN: frame 0x0003 + parity 0 -> published; frame 0x0007 + parity 0 -> parity_err, out_bus stays 0x0003.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and FSM state type for the 16-channel TDM demultiplexer.
package tdm_pkg;
  localparam int N_CH  = 16;
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    RUN    = 2'd1,
    PARITY = 2'd2
  } state_e;
endpackage

// File: rtl/tdm_demux16_if.sv
// Serial-in / parallel-out bundle of tdm_demux16, plus the FSM state for observation.
interface tdm_demux16_if;
  import tdm_pkg::*;

  // Handshake: a beat is transferred on every rising edge where in_valid is high. There is no
  // ready; the demux always accepts. in_bit/frame_sync are don't-care while in_valid is low.
  logic              in_valid;
  logic              in_bit;
  logic              frame_sync;
  logic [N_CH-1:0]   out_bus;
  logic              out_valid;
  logic              frame_err;
  logic              parity_err;
  logic [SEL_W-1:0]  cur_ch;
  state_e            dbg_state;

  modport master (
    output in_valid, in_bit, frame_sync,
    input  out_bus, out_valid, frame_err, parity_err, cur_ch, dbg_state
  );

  modport slave (
    input  in_valid, in_bit, frame_sync,
    output out_bus, out_valid, frame_err, parity_err, cur_ch, dbg_state
  );
endinterface

// File: rtl/tdm_ch_counter.sv
// Channel index counter: clear has priority over load-to-1, which has priority over increment.
module tdm_ch_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             load1,
  output logic [SEL_W-1:0] cnt,
  output logic             last
);
  logic [SEL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)        cnt_d = '0;
    else if (load1) cnt_d = SEL_W'(1);
    else if (inc)   cnt_d = cnt_q + SEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == SEL_W'(N_CH - 1));
endmodule

// File: rtl/tdm_demux16.sv
// Time-division 1-to-16 demultiplexer: reassembles serial beats into a frame word, published atomically.
// Define TDM_DEMUX_PARITY_EN to add a 17th even-parity beat per frame and the parity_err pulse.
module tdm_demux16
  import tdm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux16_if.slave  bus
);
  state_e            state_q, state_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   out_bus_q, out_bus_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              cnt_inc, cnt_clr, cnt_load1;
  logic [SEL_W-1:0]  cur_ch;
  logic              last_ch;

  tdm_ch_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .cnt   (cur_ch),
    .last  (last_ch)
  );

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    out_bus_d    = out_bus_q;
    out_valid_d  = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    cnt_inc      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load1    = 1'b0;

    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow_d[0] = bus.in_bit;
            cnt_load1   = 1'b1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (bus.frame_sync) begin
            // A sync anywhere but channel 0 aborts the partial frame and restarts on this beat.
            frame_err_d = (cur_ch != '0);
            shadow_d[0] = bus.in_bit;
            cnt_load1   = 1'b1;
          end else if (cur_ch == '0) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
          end else begin
            shadow_d[cur_ch] = bus.in_bit;
            if (last_ch) begin
`ifdef TDM_DEMUX_PARITY_EN
              state_d = PARITY;
`else
              out_bus_d   = {bus.in_bit, shadow_q[N_CH-2:0]};
              out_valid_d = 1'b1;
              cnt_clr     = 1'b1;
`endif
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
`ifdef TDM_DEMUX_PARITY_EN
        PARITY: begin
          state_d = RUN;
          if (bus.frame_sync) begin
            frame_err_d = 1'b1;
            shadow_d[0] = bus.in_bit;
            cnt_load1   = 1'b1;
          end else begin
            cnt_clr = 1'b1;
            if (^{shadow_q, bus.in_bit} == 1'b0) begin
              out_bus_d   = shadow_q;
              out_valid_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
          end
        end
`endif
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      shadow_q     <= '0;
      out_bus_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      out_bus_q    <= out_bus_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.out_bus    = out_bus_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.cur_ch     = cur_ch;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_tdm_demux16.sv
// Directed testbench for tdm_demux16; also covers the TDM_DEMUX_PARITY_EN build.
module tb_tdm_demux16;
  import tdm_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tdm_demux16_if bus ();

  tdm_demux16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: inputs change on the falling edge, outputs are sampled there too.
  task automatic drive(input logic b, input logic s);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_bit     = b;
    bus.frame_sync = s;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.in_bit     = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  task automatic send_from(input logic [15:0] w, input int start);
    for (int i = start; i < 16; i++) drive(w[i], i == 0);
`ifdef TDM_DEMUX_PARITY_EN
    drive(^w, 1'b0);
`endif
  endtask

  task automatic send_frame(input logic [15:0] w);
    send_from(w, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.frame_sync = 1'b0;
    #1;
    checks++; if (bus.out_bus !== 16'h0) begin failures++; $display("FAIL reset_out_bus got=%h exp=0000", bus.out_bus); end
    checks++; if (bus.out_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.parity_err !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got=%b%b%b exp=000", bus.out_valid, bus.frame_err, bus.parity_err); end
    checks++; if (bus.cur_ch !== 4'd0 || bus.dbg_state !== HUNT) begin
      failures++; $display("FAIL reset_state got ch=%0d st=%0d exp ch=0 st=0", bus.cur_ch, bus.dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    send_frame(16'hA5C3);
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bus !== 16'hA5C3) begin
      failures++; $display("FAIL frame_a5c3 got v=%b bus=%h exp v=1 bus=a5c3", bus.out_valid, bus.out_bus); end
    checks++; if (bus.cur_ch !== 4'd0 || bus.dbg_state !== RUN) begin
      failures++; $display("FAIL frame_a5c3_ch got ch=%0d st=%0d exp ch=0 st=1", bus.cur_ch, bus.dbg_state); end
    idle();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_bus !== 16'hA5C3) begin
      failures++; $display("FAIL frame_a5c3_hold got v=%b bus=%h exp v=0 bus=a5c3", bus.out_valid, bus.out_bus); end
  endtask

  task automatic test_back_to_back();
    send_frame(16'hFFFF);
    drive(1'b1, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bus !== 16'hFFFF) begin
      failures++; $display("FAIL b2b_first got v=%b bus=%h exp v=1 bus=ffff", bus.out_valid, bus.out_bus); end
    send_from(16'h0001, 1);
    checks++; if (bus.out_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      failures++; $display("FAIL b2b_mid got v=%b ferr=%b exp 0 0", bus.out_valid, bus.frame_err); end
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bus !== 16'h0001) begin
      failures++; $display("FAIL b2b_second got v=%b bus=%h exp v=1 bus=0001", bus.out_valid, bus.out_bus); end
  endtask

  task automatic test_sync_mid_frame();
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0);
    drive(1'b0, 1'b1);               // sync at ch7: bit0 of 0x1234
    drive(1'b0, 1'b0);
    checks++; if (bus.frame_err !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL midsync_err got ferr=%b v=%b exp 1 0", bus.frame_err, bus.out_valid); end
    checks++; if (bus.out_bus !== 16'h0001 || bus.cur_ch !== 4'd1) begin
      failures++; $display("FAIL midsync_hold got bus=%h ch=%0d exp 0001 1", bus.out_bus, bus.cur_ch); end
    send_from(16'h1234, 2);
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bus !== 16'h1234 || bus.frame_err !== 1'b0) begin
      failures++; $display("FAIL midsync_frame got v=%b bus=%h ferr=%b exp 1 1234 0", bus.out_valid, bus.out_bus, bus.frame_err); end
  endtask

  task automatic test_hunt_recovery();
    drive(1'b1, 1'b0);
    idle();
    checks++; if (bus.frame_err !== 1'b1 || bus.dbg_state !== HUNT || bus.cur_ch !== 4'd0) begin
      failures++; $display("FAIL hunt_err got ferr=%b st=%0d ch=%0d exp 1 0 0", bus.frame_err, bus.dbg_state, bus.cur_ch); end
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    idle();
    checks++; if (bus.frame_err !== 1'b0 || bus.dbg_state !== HUNT || bus.cur_ch !== 4'd0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL hunt_ignore got ferr=%b st=%0d ch=%0d v=%b exp 0 0 0 0", bus.frame_err, bus.dbg_state, bus.cur_ch, bus.out_valid); end
    checks++; if (bus.out_bus !== 16'h1234) begin
      failures++; $display("FAIL hunt_hold got bus=%h exp 1234", bus.out_bus); end
    send_frame(16'h5A5A);
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bus !== 16'h5A5A) begin
      failures++; $display("FAIL hunt_recover got v=%b bus=%h exp 1 5a5a", bus.out_valid, bus.out_bus); end
  endtask

  task automatic test_gaps_and_reset();
    logic [15:0] w;
    w = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      drive(w[i], i == 0);
      repeat ($urandom_range(0, 5)) idle();
    end
`ifdef TDM_DEMUX_PARITY_EN
    drive(^w, 1'b0);
`endif
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bus !== 16'hBEEF) begin
      failures++; $display("FAIL gaps_frame got v=%b bus=%h exp 1 beef", bus.out_valid, bus.out_bus); end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i == 0);
      repeat ($urandom_range(0, 5)) idle();
    end
    idle();
    checks++; if (bus.cur_ch !== 4'd9 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL gaps_partial got ch=%0d v=%b exp 9 0", bus.cur_ch, bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_bus !== 16'h0 || bus.cur_ch !== 4'd0 || bus.dbg_state !== HUNT) begin
      failures++; $display("FAIL async_reset got bus=%h ch=%0d st=%0d exp 0000 0 0", bus.out_bus, bus.cur_ch, bus.dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_parity();
`ifdef TDM_DEMUX_PARITY_EN
    for (int i = 0; i < 16; i++) drive(i < 2, i == 0);   // 0x0003
    drive(1'b0, 1'b0);
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bus !== 16'h0003 || bus.parity_err !== 1'b0) begin
      failures++; $display("FAIL parity_ok got v=%b bus=%h perr=%b exp 1 0003 0", bus.out_valid, bus.out_bus, bus.parity_err); end
    for (int i = 0; i < 16; i++) drive(i < 3, i == 0);   // 0x0007
    drive(1'b0, 1'b0);
    idle();
    checks++; if (bus.parity_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_bus !== 16'h0003) begin
      failures++; $display("FAIL parity_bad got perr=%b v=%b bus=%h exp 1 0 0003", bus.parity_err, bus.out_valid, bus.out_bus); end
    checks++; if (bus.cur_ch !== 4'd0 || bus.dbg_state !== RUN) begin
      failures++; $display("FAIL parity_state got ch=%0d st=%0d exp 0 1", bus.cur_ch, bus.dbg_state); end
`else
    for (int i = 0; i < 16; i++) drive(i < 3, i == 0);   // 0x0007, odd weight
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bus !== 16'h0007 || bus.parity_err !== 1'b0) begin
      failures++; $display("FAIL noparity_frame got v=%b bus=%h perr=%b exp 1 0007 0", bus.out_valid, bus.out_bus, bus.parity_err); end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_sync_mid_frame();
    test_hunt_recovery();
    test_gaps_and_reset();
    test_parity();
    repeat (2) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
